// File: rtl/dac_stream_pkg.sv
// Shared types and helpers for the DAC stream loader.
// Latency: n/a (compile-time functions and types only).
// Backpressure: n/a.
package dac_stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Whole bytes needed to carry one sample of the given width.
    function automatic int bytes_per_sample(input int width);
        return (width + 7) / 8;
    endfunction

    // Unsigned midscale code: only the sample MSB set.
    function automatic logic [31:0] midscale(input int width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/dac_stream_loader_if.sv
// Received-byte stream from the UART: one data byte plus its one-cycle strobe.
// Latency: n/a (wires only).
// Backpressure: none; the strobe is a push-only event stream.
interface dac_stream_loader_if;
    logic [7:0] rx_data;
    logic       rx_received;

    modport master (output rx_data, output rx_received);
    modport slave  (input  rx_data, input  rx_received);
endinterface

// File: rtl/frame_fifo.sv
// Single-clock frame FIFO with extra-bit pointers and a live level count.
// Latency: a push is visible in level/empty one edge later; pop data is a combinational head read.
// Backpressure: a push while full is ignored unless a pop happens on the same edge.
module frame_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (wr_ptr == rd_ptr);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since reads only follow writes.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dac_stream_loader.sv
// Builds PCM frames from UART bytes, buffers them, and releases one frame per sample tick.
// Latency: frame enters the FIFO on its last byte's edge; output updates on the tick edge.
// Backpressure: none upstream; a frame arriving at a full FIFO is dropped and flagged.
module dac_stream_loader
    import dac_stream_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 18,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int PREFILL      = 8,
    parameter int CLOCK_FREQ   = 12_000_000,
    parameter int SAMPLE_RATE  = 11_025,
    parameter int GAP_CYCLES   = 2048
) (
    input  logic                             CLK_IN,
    input  logic                             RST_N,
    dac_stream_loader_if.slave               rx,
    input  logic                             clear_flags,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
    output logic                             sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             running,
    output logic                             overrun,
    output logic                             underrun,
    output logic                             resync
);
    localparam int BPS         = bytes_per_sample(SAMPLE_WIDTH);
    localparam int FRAME_BYTES = BPS * CHANNELS;
    localparam int FW          = CHANNELS * SAMPLE_WIDTH;
    localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int DIV         = CLOCK_FREQ / SAMPLE_RATE;
    localparam int CNT_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LVL_W-1:0] PREFILL_L  = LVL_W'(PREFILL);
    localparam logic [SAMPLE_WIDTH-1:0] MID = SAMPLE_WIDTH'(midscale(SAMPLE_WIDTH));
    localparam logic [FW-1:0]    MID_FRAME  = {CHANNELS{MID}};

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [FRAME_BYTES*8-1:0] byte_buf;
    logic [FRAME_BYTES*8-1:0] frame_flat;
    logic [FW-1:0]            frame_dat;
    logic [GAP_W-1:0]         gap_cnt;
    logic [CNT_W-1:0]         tick_cnt;
    logic [FW-1:0]            pop_data;
    logic                     tick;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pad_unused;

    assign tick = (tick_cnt == '0);
    assign push = rx.rx_received && (idx == LAST_IDX);
    assign pop  = (state == RUN) && tick && !fifo_empty;

    // Padding bits above SAMPLE_WIDTH in each sample's top byte are dropped by design.
    assign pad_unused = ^frame_flat;

    // Full frame = stored bytes with the in-flight last byte on top; trim each sample to width.
    always_comb begin
        frame_flat = byte_buf;
        frame_flat[FRAME_BYTES*8-8 +: 8] = rx.rx_data;
        frame_dat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            frame_dat[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = frame_flat[c*BPS*8 +: SAMPLE_WIDTH];
        end
    end

    // Free-running sample-rate divider.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) tick_cnt <= DIV_RELOAD;
        else        tick_cnt <= tick ? DIV_RELOAD : tick_cnt - 1'b1;
    end

    // Byte assembler with idle-gap resync, plus the overrun and resync sticky flags.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            idx      <= '0;
            byte_buf <= '0;
            gap_cnt  <= '0;
            overrun  <= 1'b0;
            resync   <= 1'b0;
        end else begin
            if (clear_flags) begin
                overrun <= 1'b0;
                resync  <= 1'b0;
            end
            if (rx.rx_received) begin
                gap_cnt <= '0;
                byte_buf[idx*8 +: 8] <= rx.rx_data;
                if (idx == LAST_IDX) begin
                    idx <= '0;
                    if (fifo_full && !pop) overrun <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST && idx != '0) begin
                    idx    <= '0;
                    resync <= 1'b1;
                end
            end
        end
    end

    // Prefill/run control with registered output frame, strobe, running and underrun.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state        <= FILL;
            running      <= 1'b0;
            sample_out   <= MID_FRAME;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (clear_flags) underrun <= 1'b0;
            case (state)
                FILL: begin
                    if (fifo_level >= PREFILL_L) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (!fifo_empty) begin
                            sample_out   <= pop_data;
                            sample_valid <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                            state    <= FILL;
                            running  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= FILL;
                    running <= 1'b0;
                end
            endcase
        end
    end

    frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK_IN),
        .rst_n     (RST_N),
        .push      (push),
        .push_data (frame_dat),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_dac_stream_loader.sv
// Bench for dac_stream_loader: queue-based frame model checked every cycle plus directed checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_dac_stream_loader;
    localparam int W     = 18;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int PRE   = 8;
    localparam int CF    = 20_000;
    localparam int SR    = 100;
    localparam int GAP   = 32;
    localparam int DIV   = CF / SR;
    localparam int BPS   = 3;
    localparam int FB    = BPS * CH;
    localparam int FW    = CH * W;
    localparam logic [FW-1:0] MIDF = {2{18'h20000}};
    localparam logic [FW-1:0] F17  = {18'h15555, 18'h2AAAA};

    logic          CLK_IN = 1'b0;
    logic          RST_N  = 1'b0;
    logic          clear_flags = 1'b0;
    logic [FW-1:0] sample_out;
    logic          sample_valid;
    logic [4:0]    fifo_level;
    logic          running, overrun, underrun, resync;

    dac_stream_loader_if rx_bus();

    dac_stream_loader #(
        .SAMPLE_WIDTH (W),
        .CHANNELS     (CH),
        .FIFO_DEPTH   (DEPTH),
        .PREFILL      (PRE),
        .CLOCK_FREQ   (CF),
        .SAMPLE_RATE  (SR),
        .GAP_CYCLES   (GAP)
    ) dut (
        .CLK_IN       (CLK_IN),
        .RST_N        (RST_N),
        .rx           (rx_bus),
        .clear_flags  (clear_flags),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .fifo_level   (fifo_level),
        .running      (running),
        .overrun      (overrun),
        .underrun     (underrun),
        .resync       (resync)
    );

    always #5 CLK_IN = ~CLK_IN;

    int checks = 0;
    int fails  = 0;
    int bcyc   = 0;
    int pulse_t[$];
    logic [FW-1:0] pulse_v[$];

    // Reference model: frames as queue entries, tick phase from a cycle count.
    logic [FW-1:0] mq[$];
    logic [FW-1:0] m_out = MIDF;
    logic [7:0]    m_bytes[FB];
    int m_cyc = 0, m_idx = 0, m_idle = 0, t_lvl = 0;
    bit m_run = 0, m_valid = 0, m_over = 0, m_under = 0, m_resync = 0;
    bit t_tick, t_pop;

    function automatic logic [FW-1:0] assemble();
        longint v;
        logic [FW-1:0] f;
        f = '0;
        for (int c = 0; c < CH; c++) begin
            v = 0;
            for (int b = 0; b < BPS; b++) v += longint'(m_bytes[c*BPS+b]) << (8*b);
            v = v % (longint'(1) << W);
            f |= FW'(v) << (c*W);
        end
        return f;
    endfunction

    // Model update on each clock edge, or immediately on reset assertion.
    always @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            mq.delete();
            m_out = MIDF; m_cyc = 0; m_idx = 0; m_idle = 0;
            m_run = 0; m_valid = 0; m_over = 0; m_under = 0; m_resync = 0;
        end else begin
            t_lvl  = mq.size();
            t_tick = (m_cyc % DIV) == DIV - 1;
            m_cyc++;
            t_pop   = 0;
            m_valid = 0;
            if (clear_flags) begin m_over = 0; m_under = 0; m_resync = 0; end
            if (!m_run) m_run = (t_lvl >= PRE);
            else if (t_tick) begin
                if (t_lvl > 0) t_pop = 1;
                else begin m_under = 1; m_run = 0; end
            end
            if (t_pop) begin m_out = mq.pop_front(); m_valid = 1; end
            if (rx_bus.rx_received) begin
                m_idle = 0;
                m_bytes[m_idx] = rx_bus.rx_data;
                if (m_idx == FB - 1) begin
                    m_idx = 0;
                    if (t_lvl == DEPTH && !t_pop) m_over = 1;
                    else mq.push_back(assemble());
                end else m_idx++;
            end else begin
                m_idle++;
                if (m_idle == GAP && m_idx != 0) begin m_idx = 0; m_resync = 1; end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sample_out",   sample_out,   m_out);
        chk("sample_valid", sample_valid, m_valid);
        chk("fifo_level",   fifo_level,   mq.size());
        chk("running",      running,      m_run);
        chk("overrun",      overrun,      m_over);
        chk("underrun",     underrun,     m_under);
        chk("resync",       resync,       m_resync);
    endtask

    task automatic step();
        @(posedge CLK_IN);
        #1;
        bcyc++;
        check_all();
        if (sample_valid) begin
            pulse_t.push_back(bcyc);
            pulse_v.push_back(sample_out);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_bus.rx_data     = b;
        rx_bus.rx_received = 1'b1;
        step();
        rx_bus.rx_received = 1'b0;
        rx_bus.rx_data     = 8'($urandom);
    endtask

    task automatic send_frame(input logic [W-1:0] s0, input logic [W-1:0] s1, input int max_gap);
        logic [47:0] raw;
        raw = {6'($urandom), s1, 6'($urandom), s0};
        for (int k = 0; k < FB; k++) begin
            send_byte(raw[k*8 +: 8]);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    task automatic align_to(input int phase);
        int guard;
        guard = 0;
        while ((m_cyc % DIV) != phase && guard < 2 * DIV) begin
            step();
            guard++;
        end
        chk("align_timeout", guard < 2 * DIV, 1);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        rx_bus.rx_data     = 8'h00;
        rx_bus.rx_received = 1'b0;

        // Reset state.
        repeat (3) step();
        chk("rst_sample_out", sample_out, MIDF);
        chk("rst_level", fifo_level, 0);
        chk("rst_running", running, 0);
        chk("rst_flags", {overrun, underrun, resync, sample_valid}, 0);
        RST_N = 1'b1;

        // Prefill, drain at DIV spacing, then starve into underrun.
        pulse_t.delete(); pulse_v.delete();
        for (int i = 0; i < 8; i++) begin
            send_frame(18'(1 + i), 18'(18'h3FFFF - i), 0);
            if (i == 6) chk("t1_not_running_at_7", running, 0);
        end
        step();
        chk("t1_running_after_8", running, 1);
        repeat (9 * DIV + 5) step();
        chk("t1_pulse_count", pulse_v.size(), 8);
        for (int i = 0; i < pulse_v.size() && i < 8; i++) begin
            chk("t1_frame_order", pulse_v[i], {18'(18'h3FFFF - i), 18'(1 + i)});
            if (i > 0) chk("t1_period", pulse_t[i] - pulse_t[i-1], DIV);
        end
        chk("t1_underrun", underrun, 1);
        chk("t1_stopped", running, 0);
        chk("t1_hold_frame7", sample_out, {18'h3FFF8, 18'h00008});

        // Overrun: 17 back-to-back frames right after a tick.
        pulse_t.delete(); pulse_v.delete();
        align_to(0);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) send_frame(F17[17:0], F17[35:18], 0);
            else send_frame(18'($urandom), 18'($urandom), 0);
        end
        chk("t3_level_full", fifo_level, 16);
        chk("t3_overrun", overrun, 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("t3_overrun_cleared", overrun, 0);

        // Last byte on the tick edge at full level: push and pop together.
        align_to(DIV - FB);
        send_frame(18'($urandom), 18'($urandom), 0);
        chk("t5_pop_on_tick", sample_valid, 1);
        chk("t5_level_full", fifo_level, 16);
        chk("t5_no_overrun", overrun, 0);
        repeat (17 * DIV + 5) step();
        chk("t3_drain_count", pulse_v.size(), 17);
        for (int i = 0; i < pulse_v.size(); i++) chk("t3_f17_absent", pulse_v[i] == F17, 0);
        chk("t3_drain_underrun", underrun, 1);

        // Resync on idle, then width masking.
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        pulse_t.delete(); pulse_v.delete();
        repeat (3) send_byte(8'($urandom));
        repeat (GAP + 4) step();
        chk("t4_resync", resync, 1);
        chk("t4_partial_dropped", fifo_level, 0);
        send_frame(18'h00123, 18'h00456, 2);
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        repeat (3) send_byte(8'hFF);
        send_byte(r0); send_byte(r1); send_byte(r2);
        for (int i = 0; i < 6; i++) send_frame(18'($urandom), 18'($urandom), 3);
        repeat (3 * DIV) step();
        chk("t4_pulses", pulse_v.size() >= 2, 1);
        if (pulse_v.size() >= 2) begin
            chk("t4_frame_after_resync", pulse_v[0], {18'h00456, 18'h00123});
            chk("t2_mask_ch0", pulse_v[1][17:0], 18'h3FFFF);
            chk("t2_mask_ch1", pulse_v[1][35:18], {r2[1:0], r1, r0});
        end

        // Asynchronous reset mid-frame in RUN.
        chk("t6_in_run", running, 1);
        repeat (3) send_byte(8'($urandom));
        #3;
        RST_N = 1'b0;
        #1;
        chk("t6_async_out", sample_out, MIDF);
        chk("t6_async_level", fifo_level, 0);
        chk("t6_async_running", running, 0);
        check_all();
        repeat (2) step();
        RST_N = 1'b1;
        step();
        chk("t6_fill_after", running, 0);
        chk("t6_level_after", fifo_level, 0);
        repeat (3) send_byte(8'($urandom));
        chk("t6_index_cleared", fifo_level, 0);
        repeat (3) send_byte(8'($urandom));
        chk("t6_one_frame", fifo_level, 1);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dac_stream_loader.md
# dac_stream_loader

Assembles multi-byte, multi-channel PCM frames from the UART byte stream, buffers them in a frame FIFO, and releases one frame per sample-rate tick to the sigma-delta DAC channels. It sits between `rxuart` (byte strobe and data) and one `sigma_delta_dac` instance per channel, replacing the single-byte, unbuffered path. It adds:
- parametrised width and channel count
- underrun/overrun handling
- prefill
- resync on line idle

## Interface

Parameters:
- `SAMPLE_WIDTH`, 18: bits per channel sample, 1..32. Byte count per sample `BPS = ceil(SAMPLE_WIDTH/8)`.
- `CHANNELS`, 2: channels per frame, 1..8.
- `FIFO_DEPTH`, 16: frames buffered, power of two, ≥2.
- `PREFILL`, 8: frames required before output starts, 1..`FIFO_DEPTH`.
- `CLOCK_FREQ`, 12_000_000: `CLK_IN` frequency in Hz.
- `SAMPLE_RATE`, 11_025: frame output rate in Hz. Divider `DIV = CLOCK_FREQ/SAMPLE_RATE` (integer division).
- `GAP_CYCLES`, 2048: idle clocks after which a partial frame is discarded.

Ports:
- `CLK_IN` in 1: single clock, all logic on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_received` in 1: one-cycle strobe, `rx_data` valid.
- `clear_flags` in 1: synchronous clear of the sticky flags.
- `sample_out` out `CHANNELS*SAMPLE_WIDTH`: channel 0 in the LSBs.
- `sample_valid` out 1: one-cycle strobe when `sample_out` updates.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: frames stored.
- `running` out 1: high in RUN.
- `overrun` out 1: sticky, a frame was dropped because the FIFO was full.
- `underrun` out 1: sticky, a tick found the FIFO empty in RUN.
- `resync` out 1: sticky, a partial frame was discarded on gap timeout.

## Operation

Frame format:
- Little-endian bytes per sample, channel 0 first; `BPS*CHANNELS` bytes per frame.
- Bits of the last byte above `SAMPLE_WIDTH` are ignored.
- No header. Framing is by byte count and resync on idle.

Assembler:
- Byte index `0..BPS*CHANNELS-1` advances on each `rx_received`.
- On the last byte, the full frame (stored bytes plus the current byte) is written to the FIFO on the same edge, and the index returns to 0.
- FIFO full at that edge (level before the edge equals `FIFO_DEPTH`, with no pop on the same edge): the frame is dropped and `overrun` is set.

Gap timer:
- Resets on each strobe and counts otherwise.
- On reaching `GAP_CYCLES` with index ≠ 0: index := 0, stored bytes discarded, `resync` set.
- No effect when index = 0.

Tick:
- Down-counter loaded with `DIV-1`; tick when it reaches 0, then it reloads.
- Runs continuously from reset.

Control FSM:
- FILL (reset state): ticks are ignored. Go to RUN when `fifo_level ≥ PREFILL`.
- RUN:
  - Each tick with level > 0: pop one frame into `sample_out` and pulse `sample_valid`.
  - Tick with level = 0: set `underrun`, hold `sample_out`, go to FILL.

General:
- Push and pop on the same edge: both are performed, and the level is unchanged.
- A push on the same edge as an empty-FIFO tick is not bypassed: underrun is reported.
- `clear_flags` clears all three sticky flags. A set event on the same edge wins.

Reset values:
- `sample_out`: every channel at midscale `1<<(SAMPLE_WIDTH-1)`.
- `sample_valid`, `running`, all flags: 0.
- `fifo_level`: 0.
- Assembler index, gap timer: 0.
- Tick counter: `DIV-1`.
- FSM: FILL.

Reset mid-frame or mid-operation discards all buffered data.

## Timing

- Last-byte strobe at edge N: `fifo_level` increments after edge N.
- FILL→RUN transition occurs at the edge after the level reaches `PREFILL`.
- Tick (counter = 0) at edge T: `sample_out` and `sample_valid` are valid after edge T, for one cycle.
- Back-to-back strobes on consecutive cycles are accepted.
- Output period is exactly `DIV` clocks in steady state.

## Structure

- Package `dac_stream_pkg`:
  - function `bytes_per_sample(width)`
  - function `midscale(width)`
  - FSM state enum `{FILL, RUN}`
- Sub-module `frame_fifo`:
  - Synchronous single-clock FIFO, width `CHANNELS*SAMPLE_WIDTH`, depth `FIFO_DEPTH`.
  - Ports: push, pop, full, empty, level.
  - Pointers one bit wider than the address.
- Assembler, gap timer, tick divider and FSM live in the top module.

## Test plan

1. Prefill and drain:
   - Setup: `SAMPLE_WIDTH=18`, `CHANNELS=2`, `PREFILL=8`.
   - Stimulus: send 8 frames, channel 0 = 0x00001+i, channel 1 = 0x3FFFF-i.
   - Required response: `running` rises after frame 8; 8 `sample_valid` pulses exactly `DIV` clocks apart, in order.
   - Stimulus continues: then starve the input.
   - Required response: `underrun`=1, output holds frame 7, `running`=0.
2. Width masking:
   - Stimulus: sample bytes 0xFF,0xFF,0xFF.
   - Required response: `sample_out` channel = 0x3FFFF, channel 1 unaffected.
3. Overrun:
   - Stimulus: `FIFO_DEPTH=16`; send 17 frames faster than ticks drain them (simulation `DIV` large).
   - Required response: level=16, `overrun`=1, frame 17 never appears at the output.
   - Stimulus: `clear_flags`.
   - Required response: `overrun`=0.
4. Resync:
   - Stimulus: send 3 bytes, idle `GAP_CYCLES`, then a full frame 0x00123/0x00456.
   - Required response: `resync`=1; the output frame is 0x00123/0x00456.
5. Simultaneous push/pop at full:
   - Stimulus: level=16, last byte coincides with a tick.
   - Required response: no overrun, level stays 16.
6. Asynchronous reset:
   - Stimulus: `RST_N` low mid-frame in RUN.
   - Required response: outputs go immediately to midscale/0; after release, FILL and level=0.
